// File: rtl/orb_pkg.sv
`default_nettype none
// ============================================================================
// Module : orb_pkg
// Shared state type, word/address helpers and parameter limits for the packer.
// Rev    : 1.0  initial release
// ============================================================================
package orb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PEND  = 2'd2
    } orb_state_e;

    localparam int c_MIN_NCH = 1;
    localparam int c_MAX_NCH = 8;

    // Data sits just below the always-zero MSB, zero padded underneath.
    function automatic logic [31:0] fmt_word(input logic [31:0] data,
                                             input int dw, input int word_w);
        logic [31:0] mask;
        mask = (32'd1 << dw) - 32'd1;
        return (data & mask) << (word_w - 1 - dw);
    endfunction

    function automatic logic [31:0] pack_addr(input logic [31:0] pack,
                                              input logic [31:0] slot,
                                              input int ch, input int nch,
                                              input int wpp);
        return pack * 32'(nch) * 32'(wpp) + slot * 32'(nch) + 32'(ch);
    endfunction

    function automatic bit params_ok(input int nch, input int dw,
                                     input int word_w, input int wpp,
                                     input int spp, input int npack);
        return (nch >= c_MIN_NCH) && (nch <= c_MAX_NCH) && (word_w >= dw + 1)
            && (wpp >= 1) && (spp > wpp) && (npack >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/orb_chan_slot.sv
`default_nettype none
// ============================================================================
// Module : orb_chan_slot
// One channel: strobe sync/edge detect, slot/pack counters, delay FSM, latch.
// Rev    : 1.0  initial release
// ============================================================================
module orb_chan_slot
    import orb_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int CH             = 0,
    parameter int DW             = 8,
    parameter int WORD_W         = 12,
    parameter int ADDR_W         = 11,
    parameter int WORDS_PER_PACK = 16,
    parameter int SLOTS_PER_PACK = 20,
    parameter int NPACK          = 64,
    parameter int WE_DELAY       = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strob_i,
    input  logic              chen_i,
    input  logic [DW-1:0]     data_i,
    input  logic              clr_i,
    input  logic              grant_i,
    output logic              pend_o,
    output logic [WORD_W-1:0] word_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o,
    output logic              ovf_o
);

    localparam int SLOT_W = (SLOTS_PER_PACK > 1) ? $clog2(SLOTS_PER_PACK) : 1;
    localparam int PACK_W = (NPACK > 1) ? $clog2(NPACK) : 1;
    localparam int CNT_W  = (WE_DELAY > 0) ? $clog2(WE_DELAY + 1) : 1;

    localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(SLOTS_PER_PACK - 1);
    localparam logic [SLOT_W-1:0] c_WPP       = SLOT_W'(WORDS_PER_PACK);
    localparam logic [PACK_W-1:0] c_LAST_PACK = PACK_W'(NPACK - 1);
    localparam logic [CNT_W-1:0]  c_DELAY     = CNT_W'(WE_DELAY);

    logic [1:0]        sync_q;
    logic              prev_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PACK_W-1:0] pack_q, pack_d;
    logic [CNT_W-1:0]  cnt_q;
    orb_state_e        state_q;
    logic [WORD_W-1:0] word_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ovf_q;

    logic w_edge, w_take, w_last_slot, w_last_pack, w_delay_done;

    // A page change swallows any edge seen in the same cycle.
    assign w_edge       = sync_q[1] & ~prev_q & ~clr_i;
    assign w_take       = w_edge & chen_i & (slot_q < c_WPP);
    assign w_last_slot  = (slot_q == c_LAST_SLOT);
    assign w_last_pack  = (pack_q == c_LAST_PACK);
    assign w_delay_done = (cnt_q == '0) || (cnt_q == CNT_W'(1));

    always_comb begin
        slot_d = w_last_slot ? '0 : slot_q + SLOT_W'(1);
        pack_d = pack_q;
        if (w_last_slot) begin
            pack_d = w_last_pack ? '0 : pack_q + PACK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            slot_q  <= '0;
            pack_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            word_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], strob_i};
            prev_q <= sync_q[1];
            if (clr_i) begin
                slot_q  <= '0;
                pack_q  <= '0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
                ovf_q   <= 1'b0;
            end else begin
                if (w_edge) begin
                    slot_q <= slot_d;
                    pack_q <= pack_d;
                end
                if (w_take) begin
                    word_q  <= WORD_W'(fmt_word(32'(data_i), DW, WORD_W));
                    addr_q  <= ADDR_W'(pack_addr(32'(pack_q), 32'(slot_q), CH, NCH,
                                                 WORDS_PER_PACK));
                    cnt_q   <= c_DELAY;
                    state_q <= (WE_DELAY == 0) ? ST_PEND : ST_DELAY;
                    if (state_q != ST_IDLE) begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    case (state_q)
                        ST_DELAY: begin
                            if (w_delay_done) begin
                                state_q <= ST_PEND;
                            end else begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end
                        end
                        ST_PEND: begin
                            if (grant_i) begin
                                state_q <= ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign pend_o = (state_q == ST_PEND);
    assign word_o = word_q;
    assign addr_o = addr_q;
    assign wrap_o = w_edge & w_last_slot & w_last_pack;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/orb_packer_n.sv
`default_nettype none
// ============================================================================
// Module : orb_packer_n
// NCH-channel orbital word packer: page-select sync and shared write-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module orb_packer_n
    import orb_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int DW             = 8,
    parameter int WORD_W         = 12,
    parameter int ADDR_W         = 11,
    parameter int WORDS_PER_PACK = 16,
    parameter int SLOTS_PER_PACK = 20,
    parameter int NPACK          = 64,
    parameter int WE_DELAY       = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] iData,
    input  logic [NCH-1:0]    strob,
    input  logic [NCH-1:0]    chEn,
    input  logic              SW,
    output logic [WORD_W-1:0] orbWord,
    output logic [ADDR_W-1:0] WrAddr,
    output logic              WE,
    output logic              pageSync,
    output logic              frameDone,
    output logic [NCH-1:0]    ovf
);

    if (!params_ok(NCH, DW, WORD_W, WORDS_PER_PACK, SLOTS_PER_PACK, NPACK)) begin : g_param_err
        $error("orb_packer_n: illegal parameter combination");
    end

    logic [1:0]        sw_sync_q;
    logic              oldsw_q;
    logic              we_q, pagesync_q, framedone_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] word_q;

    logic              w_sw_chg;
    logic [NCH-1:0]    w_pend, w_grant, w_wrap, w_ovf;
    logic [WORD_W-1:0] w_word [NCH];
    logic [ADDR_W-1:0] w_addr [NCH];
    logic [WORD_W-1:0] w_sel_word;
    logic [ADDR_W-1:0] w_sel_addr;

    assign w_sw_chg = sw_sync_q[1] ^ oldsw_q;
    // Lowest pending channel wins; nobody is granted while the page changes.
    assign w_grant  = (w_pend & (~w_pend + NCH'(1))) & {NCH{~w_sw_chg}};

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        orb_chan_slot #(
            .NCH            (NCH),
            .CH             (c),
            .DW             (DW),
            .WORD_W         (WORD_W),
            .ADDR_W         (ADDR_W),
            .WORDS_PER_PACK (WORDS_PER_PACK),
            .SLOTS_PER_PACK (SLOTS_PER_PACK),
            .NPACK          (NPACK),
            .WE_DELAY       (WE_DELAY)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .strob_i (strob[c]),
            .chen_i  (chEn[c]),
            .data_i  (iData[c*DW +: DW]),
            .clr_i   (w_sw_chg),
            .grant_i (w_grant[c]),
            .pend_o  (w_pend[c]),
            .word_o  (w_word[c]),
            .addr_o  (w_addr[c]),
            .wrap_o  (w_wrap[c]),
            .ovf_o   (w_ovf[c])
        );
    end

    always_comb begin
        w_sel_word = '0;
        w_sel_addr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_grant[c]) begin
                w_sel_word = w_word[c];
                w_sel_addr = w_addr[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync_q   <= '0;
            oldsw_q     <= 1'b0;
            we_q        <= 1'b0;
            pagesync_q  <= 1'b0;
            framedone_q <= 1'b0;
            addr_q      <= '0;
            word_q      <= '0;
        end else begin
            sw_sync_q   <= {sw_sync_q[0], SW};
            oldsw_q     <= sw_sync_q[1];
            pagesync_q  <= w_sw_chg;
            framedone_q <= w_wrap[0];
            we_q        <= |w_grant;
            if (|w_grant) begin
                addr_q <= w_sel_addr;
                word_q <= w_sel_word;
            end
        end
    end

    assign orbWord   = word_q;
    assign WrAddr    = addr_q;
    assign WE        = we_q;
    assign pageSync  = pagesync_q;
    assign frameDone = framedone_q;
    assign ovf       = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_orb_packer_n.sv
`default_nettype none
// ============================================================================
// Module : tb_orb_packer_n
// Self-checking bench: directed vector table, corner sequences, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_orb_packer_n;

    localparam int NCH    = 2;
    localparam int DW     = 8;
    localparam int WORD_W = 12;
    localparam int ADDR_W = 11;
    localparam int WPP    = 16;
    localparam int SPP    = 20;
    localparam int NPACK  = 64;
    localparam int DLY    = 30;

    logic              clk, rst, SW;
    logic [NCH*DW-1:0] iData;
    logic [NCH-1:0]    strob, chEn, ovf;
    logic [WORD_W-1:0] orbWord;
    logic [ADDR_W-1:0] WrAddr;
    logic              WE, pageSync, frameDone;

    orb_packer_n #(
        .NCH(NCH), .DW(DW), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
        .WORDS_PER_PACK(WPP), .SLOTS_PER_PACK(SPP), .NPACK(NPACK), .WE_DELAY(DLY)
    ) dut (
        .clk(clk), .rst(rst), .iData(iData), .strob(strob), .chEn(chEn), .SW(SW),
        .orbWord(orbWord), .WrAddr(WrAddr), .WE(WE), .pageSync(pageSync),
        .frameDone(frameDone), .ovf(ovf)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } wr_t;

    typedef struct {
        int                ch;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } exp_t;

    typedef struct {
        logic [1:0]        mask;
        logic [1:0]        en;
        logic [7:0]        d0;
        logic [7:0]        d1;
        int                n;
        logic [ADDR_W-1:0] a0;
        logic [WORD_W-1:0] w0;
        logic [ADDR_W-1:0] a1;
        logic [WORD_W-1:0] w1;
    } vec_t;

    wr_t  log_q[$];
    exp_t exp_q[$];
    int   cyc, t_set, n_ps, n_fd, n_pass, n_total;
    int   ncnt[NCH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (WE) log_q.push_back('{cyc, WrAddr, orbWord});
        if (pageSync) n_ps = n_ps + 1;
        if (frameDone) n_fd = n_fd + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic check_wr(input string name, input int idx,
                            input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w);
        if (idx >= log_q.size()) begin
            check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            check({name, "_addr"}, 32'(log_q[idx].addr), 32'(a));
            check({name, "_word"}, 32'(log_q[idx].word), 32'(w));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_WE"}, 32'(WE), 0);
        check({name, "_WrAddr"}, 32'(WrAddr), 0);
        check({name, "_orbWord"}, 32'(orbWord), 0);
        check({name, "_pageSync"}, 32'(pageSync), 0);
        check({name, "_frameDone"}, 32'(frameDone), 0);
        check({name, "_ovf"}, 32'(ovf), 0);
    endtask

    task automatic pulse(input logic [1:0] mask, input int hold, input int low);
        strob = mask;
        t_set = cyc;
        tick(hold);
        strob = 2'b00;
        tick(low);
    endtask

    task automatic toggle_sw();
        SW = ~SW;
        tick(6);
    endtask

    // Reference: the n-th edge of a channel lands in slot n%SPP of pack n/SPP.
    task automatic model_strobe(input int c, input logic [7:0] d, input logic en);
        int slot, pack;
        slot = ncnt[c] % SPP;
        pack = (ncnt[c] / SPP) % NPACK;
        if (en && slot < WPP)
            exp_q.push_back('{c, ADDR_W'((pack * NCH * WPP + slot * NCH + c) % (1 << ADDR_W)),
                               WORD_W'(32'(d) << (WORD_W - 1 - DW))});
        ncnt[c]++;
    endtask

    initial begin
        vec_t vt[5];
        int   base, hold[NCH], cool[NCH], k, c;
        logic [7:0] d;
        logic en;
        wr_t  e;

        vt[0] = '{2'b11, 2'b11, 8'h11, 8'h22, 2, 11'd0, 12'h088, 11'd1, 12'h110};
        vt[1] = '{2'b01, 2'b11, 8'h3C, 8'h00, 1, 11'd2, 12'h1E0, 11'd0, 12'h000};
        vt[2] = '{2'b10, 2'b11, 8'h00, 8'hFF, 1, 11'd3, 12'h7F8, 11'd0, 12'h000};
        vt[3] = '{2'b11, 2'b01, 8'h80, 8'h55, 1, 11'd4, 12'h400, 11'd0, 12'h000};
        vt[4] = '{2'b11, 2'b11, 8'h01, 8'h02, 2, 11'd6, 12'h008, 11'd7, 12'h010};

        cyc = 0; n_ps = 0; n_fd = 0; n_pass = 0; n_total = 0;
        for (int i = 0; i < NCH; i++) begin ncnt[i] = 0; hold[i] = 0; cool[i] = 0; end
        rst = 1'b1; SW = 1'b0; iData = '0; strob = '0; chEn = '0;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(3);
        check("post_reset_WE", 32'(WE), 0);

        // Single channel: latency, slot stride, skipped slots, next pack.
        chEn = 2'b11;
        iData[7:0] = 8'hA5;
        log_q.delete();
        for (int s = 0; s < 21; s++) begin
            pulse(2'b01, 4, 36);
            if (s == 0) begin
                check("single_first_we_cycle", 32'(log_q.size() > 0 ? log_q[0].cyc : -1),
                      32'(t_set + DLY + 4));
                check_wr("single_first", 0, 11'd0, 12'h528);
            end
        end
        check("single_we_count", 32'(log_q.size()), 17);
        for (int s = 1; s < 16; s++) check_wr("single_slot", s, ADDR_W'(2 * s), 12'h528);
        check_wr("single_next_pack", 16, 11'd32, 12'h528);

        base = n_ps;
        toggle_sw();
        check("sw_toggle_pagesync", 32'(n_ps), 32'(base + 1));

        for (int v = 0; v < 5; v++) begin
            log_q.delete();
            chEn = vt[v].en;
            iData = {vt[v].d1, vt[v].d0};
            pulse(vt[v].mask, 4, 41);
            check($sformatf("vec%0d_count", v), 32'(log_q.size()), 32'(vt[v].n));
            check_wr($sformatf("vec%0d_w0", v), 0, vt[v].a0, vt[v].w0);
            check($sformatf("vec%0d_latency", v), 32'(log_q.size() > 0 ? log_q[0].cyc : -1),
                  32'(t_set + DLY + 4));
            if (vt[v].n == 2) begin
                check_wr($sformatf("vec%0d_w1", v), 1, vt[v].a1, vt[v].w1);
                check($sformatf("vec%0d_back_to_back", v),
                      32'(log_q.size() > 1 ? log_q[1].cyc - log_q[0].cyc : -1), 1);
            end
        end

        // Overrun on ch1: second edge 10 cycles after the first.
        toggle_sw();
        chEn = 2'b11;
        log_q.delete();
        iData[15:8] = 8'h33;
        pulse(2'b10, 4, 6);
        iData[15:8] = 8'h44;
        pulse(2'b10, 4, 45);
        check("ovr_count", 32'(log_q.size()), 1);
        check_wr("ovr_write", 0, 11'd3, 12'h220);
        check("ovr_latency", 32'(log_q.size() > 0 ? log_q[0].cyc : -1), 32'(t_set + DLY + 4));
        check("ovr_flag", 32'(ovf), 32'h2);
        toggle_sw();
        check("ovr_cleared_by_sw", 32'(ovf), 0);

        // Page change while a write is still delayed.
        log_q.delete();
        for (int s = 0; s < 5; s++) begin
            iData[7:0] = 8'(8'h10 + s);
            pulse(2'b01, 4, 36);
        end
        check("mid_pack_five_words", 32'(log_q.size()), 5);
        check_wr("mid_pack_last", 4, 11'd8, 12'h0A0);
        base = n_ps;
        iData[7:0] = 8'h66;
        pulse(2'b01, 4, 6);
        toggle_sw();
        tick(50);
        check("mid_pack_pagesync", 32'(n_ps), 32'(base + 1));
        check("mid_pack_dropped", 32'(log_q.size()), 5);
        iData[7:0] = 8'h77;
        pulse(2'b01, 4, 40);
        check_wr("mid_pack_restart", 5, 11'd0, 12'h3B8);

        // Full frame on ch0.
        toggle_sw();
        base = n_fd;
        iData[7:0] = 8'h01;
        for (int s = 0; s < NPACK * SPP - 1; s++) pulse(2'b01, 4, 4);
        check("wrap_not_early", 32'(n_fd), 32'(base));
        pulse(2'b01, 4, 4);
        tick(6);
        check("wrap_framedone_once", 32'(n_fd), 32'(base + 1));
        tick(50);
        log_q.delete();
        iData[7:0] = 8'h5A;
        pulse(2'b01, 4, 40);
        check("wrap_next_addr_count", 32'(log_q.size()), 1);
        check_wr("wrap_next", 0, 11'd0, 12'h2D0);

        // Reset while a write is in its delay.
        log_q.delete();
        iData[7:0] = 8'hC3;
        pulse(2'b01, 4, 6);
        base = n_ps;
        rst = 1'b1;
        SW = 1'b0;
        tick(1);
        check_idle_outputs("rst_mid");
        tick(4);
        rst = 1'b0;
        tick(50);
        check("rst_no_write", 32'(log_q.size()), 0);
        check("rst_no_pagesync", 32'(n_ps), 32'(base));
        check_idle_outputs("rst_after");

        // Random traffic on both channels against the slot/pack model.
        log_q.delete();
        for (int t = 0; t < 3000; t++) begin
            for (c = 0; c < NCH; c++) begin
                if (hold[c] > 0) begin
                    hold[c]--;
                    if (hold[c] == 0) strob[c] = 1'b0;
                end
                if (cool[c] > 0) cool[c]--;
                else if ($urandom_range(0, 7) == 0) begin
                    d = 8'($urandom);
                    en = ($urandom_range(0, 3) != 0);
                    iData[c*DW +: DW] = d;
                    chEn[c] = en;
                    strob[c] = 1'b1;
                    hold[c] = $urandom_range(3, 5);
                    cool[c] = $urandom_range(40, 70);
                    model_strobe(c, d, en);
                end
            end
            @(negedge clk);
        end
        tick(6);
        strob = '0;
        tick(80);
        for (int i = 0; i < log_q.size(); i++) begin
            e = log_q[i];
            c = int'(e.addr[0]);
            k = -1;
            for (int j = 0; j < exp_q.size(); j++) begin
                if (k < 0 && exp_q[j].ch == c) k = j;
            end
            if (k < 0) begin
                check("rnd_unexpected_write", 32'(e.addr), 32'hFFFF_FFFF);
            end else begin
                check("rnd_addr", 32'(e.addr), 32'(exp_q[k].addr));
                check("rnd_word", 32'(e.word), 32'(exp_q[k].word));
                exp_q.delete(k);
            end
        end
        check("rnd_all_written", 32'(exp_q.size()), 0);
        check("rnd_no_ovf", 32'(ovf), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
